calc_exec_ctrl: RTL and testbench

CALC_EXEC_CTRL -- requirements
Module: calc_exec_ctrl

---
 rtl/calc_exec_ctrl_pkg.sv | 12 +
 rtl/calc_bit_alu.sv | 18 +
 rtl/calc_exec_ctrl.sv | 95 +++++++++
 tb/tb_calc_exec_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/calc_exec_ctrl_pkg.sv
// calc_exec_ctrl_pkg: op codes, FSM states and op validity helper shared by the calculator
package calc_exec_ctrl_pkg;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  function automatic logic op_valid(input logic [2:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
  endfunction
endpackage

// File: rtl/calc_bit_alu.sv
// calc_bit_alu: one-bit adder/subtractor/logic slice used by the serial datapath
module calc_bit_alu
  import calc_exec_ctrl_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       s,
  output logic       cout
);
  logic bx;
  always_comb begin
    bx = (op == OP_SUB) ? ~b : b;
    s = (op == OP_AND) ? a & b : (op == OP_OR) ? a | b : (op == OP_XOR) ? a ^ b : a ^ bx ^ cin;
    cout = (op == OP_ADD || op == OP_SUB) ? (a & bx) | (cin & (a ^ bx)) : 1'b0;
  end
endmodule

// File: rtl/calc_exec_ctrl.sv
// calc_exec_ctrl: bit-serial ALU controller, one bit per clock LSB first
module calc_exec_ctrl
  import calc_exec_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             end_obl,
  output logic             err
);
  localparam int CW = $clog2(WIDTH);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic [2:0] op_q, op_d;
  logic cy_q, cy_d, carry_q, carry_d, err_q, err_d;
  logic s, cout;
  calc_bit_alu u_alu (.a(a_q[0]), .b(b_q[0]), .cin(cy_q), .op(op_q), .s(s), .cout(cout));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    op_d = op_q;
    cy_d = cy_q;
    result_d = result_q;
    carry_d = carry_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start) begin
        a_d = a_in;
        b_d = b_in;
        op_d = op;
        cnt_d = '0;
        cy_d = (op == OP_SUB);
        err_d = !op_valid(op);
        state_d = op_valid(op) ? RUN : DONE;
      end
      RUN: begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        acc_d = WIDTH'({s, acc_q} >> 1);
        cy_d = cout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d = acc_d;
          carry_d = cout;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      op_q <= '0;
      cy_q <= 1'b0;
      result_q <= '0;
      carry_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      op_q <= op_d;
      cy_q <= cy_d;
      result_q <= result_d;
      carry_q <= carry_d;
      err_q <= err_d;
    end
  end
  assign result = result_q;
  assign carry = carry_q;
  assign zero = (result_q == '0);
  assign busy = (state_q != IDLE);
  assign end_obl = (state_q == DONE);
  assign err = err_q;
endmodule

// File: tb/tb_calc_exec_ctrl.sv
// tb_calc_exec_ctrl: directed scoreboard bench for the bit-serial calculator
module tb_calc_exec_ctrl;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic [W-1:0] result;
  logic carry, zero, busy, end_obl, err;
  typedef struct {
    logic [W-1:0] res;
    logic cy;
    logic er;
    int lat;
  } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;
  logic [W-1:0] m_res = '0;
  logic m_cy = 1'b0;
  calc_exec_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .result(result), .carry(carry), .zero(zero), .busy(busy), .end_obl(end_obl), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit disturb, input string tag);
    exp_t e, g;
    logic [W:0] t;
    bit valid;
    int n, pulses;
    valid = 1'b1;
    t = '0;
    case (o)
      3'd2: t = {1'b0, a} + {1'b0, b};
      3'd3: t = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      3'd4: t = {1'b0, a & b};
      3'd5: t = {1'b0, a | b};
      3'd6: t = {1'b0, a ^ b};
      default: valid = 1'b0;
    endcase
    if (valid) begin
      m_res = t[W-1:0];
      m_cy = t[W];
    end
    e = '{m_res, m_cy, !valid, valid ? W + 1 : 1};
    sb.push_back(e);
    @(negedge clk);
    op = o;
    a_in = a;
    b_in = b;
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        if (valid) chk({tag, "_errclr"}, err, 0);
        if (disturb) begin
          a_in = ~a;
          b_in = ~b;
          op = 3'd6;
        end
      end
      if (disturb && n == 3) start = 1'b1;
      if (disturb && n == 4) start = 1'b0;
    end while (!end_obl && n < 20);
    g = sb.pop_front();
    chk({tag, "_done"}, end_obl, 1);
    chk({tag, "_lat"}, n, g.lat);
    chk({tag, "_result"}, result, g.res);
    chk({tag, "_carry"}, carry, g.cy);
    chk({tag, "_zero"}, zero, g.res == '0);
    chk({tag, "_err"}, err, g.er);
    if (disturb) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_pulse1"}, end_obl, 0);
    chk({tag, "_idle"}, busy, 0);
    if (disturb) begin
      pulses = 0;
      repeat (12) begin
        @(negedge clk);
        if (end_obl || busy) pulses++;
      end
      chk({tag, "_noextra"}, pulses, 0);
    end
  endtask
  initial begin
    int n, pulses;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_result", result, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 1);
    chk("rst_busy", busy, 0);
    chk("rst_end", end_obl, 0);
    chk("rst_err", err, 0);
    run_op(3'd2, 8'h7F, 8'h01, 1'b0, "add_7f_01");
    run_op(3'd3, 8'h05, 8'h05, 1'b0, "sub_05_05");
    run_op(3'd3, 8'h03, 8'h05, 1'b0, "sub_03_05");
    run_op(3'd2, 8'hFF, 8'h01, 1'b0, "add_ff_01");
    run_op(3'd6, 8'hF0, 8'hFF, 1'b0, "xor_f0_ff");
    run_op(3'd1, 8'h12, 8'h34, 1'b0, "invalid_1");
    chk("err_hold", err, 1);
    run_op(3'd4, 8'h3C, 8'h0F, 1'b1, "and_disturb");
    run_op(3'd5, 8'h50, 8'h0A, 1'b0, "or_50_0a");
    run_op(3'd7, 8'h00, 8'h00, 1'b0, "invalid_7");
    @(negedge clk);
    op = 3'd2;
    a_in = 8'h11;
    b_in = 8'h22;
    start = 1'b1;
    for (n = 1; n <= 4; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_res = '0;
    m_cy = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_zero", zero, 1);
    chk("abort_carry", carry, 0);
    chk("abort_end", end_obl, 0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (end_obl) pulses++;
    end
    chk("abort_nopulse", pulses, 0);
    run_op(3'd2, 8'h02, 8'h03, 1'b0, "add_after_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
